// File: rtl/fila_pkg.sv
// rtl/fila_pkg.sv - shared types and sizes for the fila queue and its command front-end
package fila_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE_ENQ, ISSUE_DEQ, HOLD} cmd_state_t;
  localparam int FILA_DEPTH = 8;
  localparam int FILA_W     = 8;
endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchronizer, stability counter and press (rise) pulse for one button
module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic rise_o
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  // The level flips on the DEB_CYCLES-th consecutive cycle of disagreement.
  assign flip = (sync2_q != deb_q) && (cnt_q == CW'(DEB_CYCLES - 1));

  always_comb begin
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    rise_d = flip & sync2_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (flip) begin
      cnt_d = '0;
      deb_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
    end
  end

  assign rise_o = rise_q;
endmodule

// File: rtl/fila_cmd_gen.sv
// rtl/fila_cmd_gen.sv - turns debounced button presses into spaced enqueue/dequeue strobes for fila
module fila_cmd_gen
  import fila_pkg::*;
#(
  parameter int DEB_CYCLES = 20,
  parameter int HOLDOFF    = 3,
  parameter int DEPTH      = FILA_DEPTH
) (
  input  logic              clk_10KHz,
  input  logic              reset,
  input  logic              btn_enq,
  input  logic              btn_deq,
  input  logic [FILA_W-1:0] sw_data,
  input  logic [FILA_W-1:0] len_in,
  output logic [FILA_W-1:0] data_out,
  output logic              enqueue_out,
  output logic              dequeue_out,
  output logic              busy_out,
  output logic              reject_out
);
  localparam int HW = $clog2(HOLDOFF + 1);

  cmd_state_t        state_q, state_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [FILA_W-1:0] sw_s1_q, sw_s2_q;
  logic [FILA_W-1:0] data_q, data_d;
  logic              enq_q, enq_d, deq_q, deq_d, busy_q, busy_d, rej_q, rej_d;
  logic              enq_rise, deq_rise, full, empty;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enq (
    .clk_i (clk_10KHz),
    .rst_i (reset),
    .btn_i (btn_enq),
    .rise_o(enq_rise)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_deq (
    .clk_i (clk_10KHz),
    .rst_i (reset),
    .btn_i (btn_deq),
    .rise_o(deq_rise)
  );

  assign full  = (len_in >= FILA_W'(DEPTH));
  assign empty = (len_in == '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    data_d  = data_q;
    enq_d   = 1'b0;
    deq_d   = 1'b0;
    rej_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // Simultaneous presses: enqueue wins, the dequeue is dropped.
        if (enq_rise) begin
          rej_d = full | deq_rise;
          if (!full) begin
            state_d = ISSUE_ENQ;
            enq_d   = 1'b1;
            data_d  = sw_s2_q;
          end
        end else if (deq_rise) begin
          if (empty) begin
            rej_d = 1'b1;
          end else begin
            state_d = ISSUE_DEQ;
            deq_d   = 1'b1;
          end
        end
      end
      ISSUE_ENQ, ISSUE_DEQ: begin
        state_d = HOLD;
        hold_d  = '0;
        rej_d   = enq_rise | deq_rise;
      end
      HOLD: begin
        rej_d = enq_rise | deq_rise;
        if (hold_q == HW'(HOLDOFF - 1)) begin
          state_d = IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      data_q  <= '0;
      enq_q   <= 1'b0;
      deq_q   <= 1'b0;
      busy_q  <= 1'b0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sw_s1_q <= sw_data;
      sw_s2_q <= sw_s1_q;
      data_q  <= data_d;
      enq_q   <= enq_d;
      deq_q   <= deq_d;
      busy_q  <= busy_d;
      rej_q   <= rej_d;
    end
  end

  assign data_out    = data_q;
  assign enqueue_out = enq_q;
  assign dequeue_out = deq_q;
  assign busy_out    = busy_q;
  assign reject_out  = rej_q;
endmodule

// File: tb/tb_fila_cmd_gen.sv
// tb/tb_fila_cmd_gen.sv - scoreboard bench for fila_cmd_gen with DEB_CYCLES=4, HOLDOFF=3
module tb_fila_cmd_gen;
  localparam int DEB = 4;
  localparam int LAT = 2 + DEB + 1;

  typedef struct {
    int         kind;   // 0 enqueue, 1 dequeue, 2 reject
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_enq = 1'b0, btn_deq = 1'b0;
  logic [7:0] sw_data = 8'h00, len_in = 8'h00;
  logic [7:0] data_out;
  logic       enqueue_out, dequeue_out, busy_out, reject_out;

  int  passes = 0, total = 0, cyc = 0, busy_cnt = 0, h;
  ev_t sb[$];

  fila_cmd_gen #(.DEB_CYCLES(DEB), .HOLDOFF(3), .DEPTH(8)) dut (
    .clk_10KHz  (clk),
    .reset      (reset),
    .btn_enq    (btn_enq),
    .btn_deq    (btn_deq),
    .sw_data    (sw_data),
    .len_in     (len_in),
    .data_out   (data_out),
    .enqueue_out(enqueue_out),
    .dequeue_out(dequeue_out),
    .busy_out   (busy_out),
    .reject_out (reject_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d, input int at);
    ev_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic take(input int kind, input logic [7:0] d);
    ev_t e;
    if (sb.size() == 0) begin
      chk("unexpected_event", kind, 32'hFF);
    end else begin
      e = sb.pop_front();
      chk("ev_kind", kind, e.kind);
      chk("ev_cycle", cyc, e.cyc);
      if (kind == 0) chk("ev_data", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (enqueue_out) take(0, data_out);
    if (dequeue_out) take(1, 8'h00);
    if (reject_out)  take(2, 8'h00);
    if (busy_out) busy_cnt++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tap(input bit e, input bit d, input int hold);
    btn_enq = e;
    btn_deq = d;
    step(hold);
    btn_enq = 1'b0;
    btn_deq = 1'b0;
    step(14);
  endtask

  initial begin
    step(2);
    chk("rst_enq", enqueue_out, 0);
    chk("rst_deq", dequeue_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_rej", reject_out, 0);
    chk("rst_data", data_out, 0);
    reset = 1'b0;

    // clean enqueue: latency, data and busy length
    sw_data = 8'h5A; len_in = 8'd0;
    step(3);
    busy_cnt = 0;
    h = cyc;
    expect_ev(0, 8'h5A, h + LAT);
    tap(1, 0, 8);
    chk("t2_busy_len", busy_cnt, 4);
    chk("t2_data_hold", data_out, 8'h5A);
    chk("t2_sb_empty", sb.size(), 0);

    // bounce never settles for DEB cycles, then a clean hold
    sw_data = 8'hC3; len_in = 8'd2;
    step(3);
    repeat (4) begin
      btn_enq = 1'b1; step(3);
      btn_enq = 1'b0; step(1);
    end
    h = cyc;
    expect_ev(0, 8'hC3, h + LAT);
    tap(1, 0, 8);
    chk("t3_data_hold", data_out, 8'hC3);
    chk("t3_sb_empty", sb.size(), 0);

    // simultaneous presses
    sw_data = 8'h11; len_in = 8'd3;
    step(3);
    h = cyc;
    expect_ev(0, 8'h11, h + LAT);
    expect_ev(2, 8'h00, h + LAT);
    tap(1, 1, 8);
    chk("t4_sb_empty", sb.size(), 0);

    // occupancy boundaries
    len_in = 8'd0; h = cyc;
    expect_ev(2, 8'h00, h + LAT);
    tap(0, 1, 8);
    len_in = 8'd8; sw_data = 8'h99; h = cyc;
    expect_ev(2, 8'h00, h + LAT);
    tap(1, 0, 8);
    chk("t5_data_hold", data_out, 8'h11);
    len_in = 8'd7; sw_data = 8'hE7; step(3); h = cyc;
    expect_ev(0, 8'hE7, h + LAT);
    tap(1, 0, 8);
    len_in = 8'd1; h = cyc;
    expect_ev(1, 8'h00, h + LAT);
    tap(0, 1, 8);
    chk("t5_sb_empty", sb.size(), 0);

    // enqueue press landing in HOLD after a dequeue
    len_in = 8'd5; sw_data = 8'hA7; step(3);
    h = cyc;
    expect_ev(1, 8'h00, h + LAT);
    btn_deq = 1'b1;
    step(3);
    expect_ev(2, 8'h00, h + 3 + LAT);
    tap(1, 1, 8);
    h = cyc;
    expect_ev(0, 8'hA7, h + LAT);
    tap(1, 0, 8);
    chk("t6_sb_empty", sb.size(), 0);

    // reset asserted mid-HOLD
    len_in = 8'd0; sw_data = 8'h3C; step(3);
    h = cyc;
    expect_ev(0, 8'h3C, h + LAT);
    btn_enq = 1'b1;
    step(8);
    chk("t1_pre_busy", busy_out, 1);
    btn_enq = 1'b0;
    reset = 1'b1;
    #1;
    chk("t1_rst_enq", enqueue_out, 0);
    chk("t1_rst_deq", dequeue_out, 0);
    chk("t1_rst_busy", busy_out, 0);
    chk("t1_rst_rej", reject_out, 0);
    chk("t1_rst_data", data_out, 0);
    step(2);
    reset = 1'b0;
    step(3);
    h = cyc;
    expect_ev(0, 8'h3C, h + LAT);
    tap(1, 0, 8);
    chk("t1_data_after", data_out, 8'h3C);

    step(5);
    chk("final_sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
